// File: rtl/pulse_gen_pkg.sv
// Shared types and helpers for the pulse train generator.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package pulse_gen_pkg;

    // Burst FSM states; outputs are decoded from the registered state.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Phase timer width: enough bits to hold the longer of the two phase lengths, plus one.
    function automatic int timer_width(input int high_cyc, input int gap_cyc);
        int longest;
        longest = (high_cyc > gap_cyc) ? high_cyc : gap_cyc;
        return $clog2(longest) + 1;
    endfunction

endpackage

// File: rtl/phase_timer.sv
// Loadable down-counter that times the HIGH and LOW phases of each pulse.
// Latency: load takes effect at the next edge; expired is decoded from the count register.
// Backpressure: none; en simply freezes the count when low.
module phase_timer
    import pulse_gen_pkg::*;
#(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         res,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         expired
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: a load wins over counting; counting stops at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (en && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        if (res) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == '0);

endmodule

// File: rtl/pulse_train_gen.sv
// Converts an accepted binary count into that many clean clk-synchronous pulses.
// Latency: first pulse is high in the cycle after the handshake edge; done follows the last pulse.
// Backpressure: start_ready is low outside IDLE and while abort is high; requests there are dropped.
module pulse_train_gen
    import pulse_gen_pkg::*;
#(
    parameter int WIDTH    = 3,
    parameter int HIGH_CYC = 1,
    parameter int GAP_CYC  = 1
) (
    input  logic             clk,
    input  logic             res,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] count,
    input  logic             abort,
    output logic             pulse,
    output logic             busy,
    output logic [WIDTH-1:0] remaining,
    output logic             done
);

    localparam int TW = timer_width(HIGH_CYC, GAP_CYC);
    localparam logic [TW-1:0] HIGH_LOAD = TW'(HIGH_CYC - 1);
    localparam logic [TW-1:0] GAP_LOAD  = TW'(GAP_CYC - 1);

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] rem_d;
    logic             pulse_q;
    logic             busy_q;
    logic             done_q;

    logic             tmr_load;
    logic [TW-1:0]    tmr_val;
    logic             tmr_en;
    logic             tmr_expired;

    assign start_ready = (state_q == IDLE) && !abort;

    phase_timer #(
        .W (TW)
    ) u_phase_timer (
        .clk      (clk),
        .res      (res),
        .load     (tmr_load),
        .load_val (tmr_val),
        .en       (tmr_en),
        .expired  (tmr_expired)
    );

    // Next-state, remaining-count and timer control for the burst sequencer.
    always_comb begin
        state_d  = state_q;
        rem_d    = rem_q;
        tmr_load = 1'b0;
        tmr_val  = HIGH_LOAD;
        tmr_en   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_valid && start_ready) begin
                    if (count != '0) begin
                        // First pulse starts immediately, so it is already "started".
                        rem_d    = count - 1'b1;
                        state_d  = HIGH;
                        tmr_load = 1'b1;
                        tmr_val  = HIGH_LOAD;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            HIGH: begin
                if (abort) begin
                    state_d = IDLE;
                    rem_d   = '0;
                end else if (tmr_expired) begin
                    if (rem_q == '0) begin
                        state_d = DONE;
                    end else begin
                        state_d  = LOW;
                        tmr_load = 1'b1;
                        tmr_val  = GAP_LOAD;
                    end
                end else begin
                    tmr_en = 1'b1;
                end
            end
            LOW: begin
                if (abort) begin
                    state_d = IDLE;
                    rem_d   = '0;
                end else if (tmr_expired) begin
                    // Leaving the gap starts the next pulse; remaining never wraps.
                    if (rem_q != '0) begin
                        rem_d = rem_q - 1'b1;
                    end
                    state_d  = HIGH;
                    tmr_load = 1'b1;
                    tmr_val  = HIGH_LOAD;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, count and outputs registered together so pulse/busy/done never glitch.
    always_ff @(posedge clk) begin
        if (res) begin
            state_q <= IDLE;
            rem_q   <= '0;
            pulse_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            pulse_q <= (state_d == HIGH);
            busy_q  <= (state_d == HIGH) || (state_d == LOW);
            done_q  <= (state_d == DONE);
        end
    end

    assign pulse     = pulse_q;
    assign busy      = busy_q;
    assign remaining = rem_q;
    assign done      = done_q;

endmodule

// File: tb/tb_pulse_train_gen.sv
// Bench for pulse_train_gen: two instances (1/1 and 2/3 phase lengths) share one stimulus stream.
// Expected per-cycle outputs come from a closed-form burst model (period arithmetic).
// Pulses are also counted by a bench counter clocked by each pulse output.
module tb_pulse_train_gen;

    localparam int W  = 3;
    localparam int H1 = 1;
    localparam int G1 = 1;
    localparam int H2 = 2;
    localparam int G2 = 3;

    typedef struct {
        bit p;
        bit b;
        bit d;
        bit r;
        int rem;
    } exp_t;

    logic         clk;
    logic         res;
    logic         start_valid;
    logic [W-1:0] count;
    logic         abort;

    logic         ready1, pulse1, busy1, done1;
    logic [W-1:0] rem1;
    logic         ready2, pulse2, busy2, done2;
    logic [W-1:0] rem2;

    int n_chk  = 0;
    int n_pass = 0;
    int pc1    = 0;
    int pc2    = 0;

    pulse_train_gen #(.WIDTH(W), .HIGH_CYC(H1), .GAP_CYC(G1)) u_dut1 (
        .clk         (clk),
        .res         (res),
        .start_valid (start_valid),
        .start_ready (ready1),
        .count       (count),
        .abort       (abort),
        .pulse       (pulse1),
        .busy        (busy1),
        .remaining   (rem1),
        .done        (done1)
    );

    pulse_train_gen #(.WIDTH(W), .HIGH_CYC(H2), .GAP_CYC(G2)) u_dut2 (
        .clk         (clk),
        .res         (res),
        .start_valid (start_valid),
        .start_ready (ready2),
        .count       (count),
        .abort       (abort),
        .pulse       (pulse2),
        .busy        (busy2),
        .remaining   (rem2),
        .done        (done2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Downstream counters clocked by the pulse outputs.
    always @(posedge pulse1) pc1 = pc1 + 1;
    always @(posedge pulse2) pc2 = pc2 + 1;

    task automatic check(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    // Expected outputs c cycles after acceptance of a count-n burst, undisturbed.
    function automatic exp_t model_raw(input int n, input int h, input int g, input int c);
        exp_t e;
        int burst;
        e.p = 0; e.b = 0; e.d = 0; e.r = 1; e.rem = 0;
        if (n == 0) begin
            if (c == 0) begin e.d = 1; e.r = 0; end
            return e;
        end
        burst = n * h + (n - 1) * g;
        if (c < burst) begin
            e.b   = 1;
            e.r   = 0;
            e.p   = ((c % (h + g)) < h);
            e.rem = n - 1 - c / (h + g);
        end else if (c == burst) begin
            e.d = 1;
            e.r = 0;
        end
        return e;
    endfunction

    // A cut (abort or reset during cycle cut) takes effect if it is a reset or the unit was busy.
    function automatic bit cut_hits(input int n, input int h, input int g, input int cut, input bit is_rst);
        exp_t e;
        if (cut < 0) return 0;
        e = model_raw(n, h, g, cut);
        return is_rst || e.b;
    endfunction

    function automatic exp_t model(input int n, input int h, input int g, input int c,
                                   input int cut, input bit is_rst);
        exp_t e;
        if (cut_hits(n, h, g, cut, is_rst) && c > cut) begin
            e.p = 0; e.b = 0; e.d = 0; e.r = 1; e.rem = 0;
            return e;
        end
        return model_raw(n, h, g, c);
    endfunction

    function automatic int pulses_exp(input int n, input int h, input int g, input int cut, input bit is_rst);
        int k;
        if (!cut_hits(n, h, g, cut, is_rst)) return n;
        k = 0;
        while (k < n && k * (h + g) <= cut) k++;
        return k;
    endfunction

    function automatic int end_cycle(input int n, input int h, input int g, input int cut, input bit is_rst);
        if (cut_hits(n, h, g, cut, is_rst)) return cut + 1;
        return (n == 0) ? 1 : n * h + (n - 1) * g + 1;
    endfunction

    task automatic cmp(input string who, input int c, input exp_t e,
                       input logic p, input logic b, input logic d, input logic r, input logic [W-1:0] rm);
        check($sformatf("%s pulse c%0d", who, c), int'(p), int'(e.p));
        check($sformatf("%s busy c%0d", who, c), int'(b), int'(e.b));
        check($sformatf("%s done c%0d", who, c), int'(d), int'(e.d));
        check($sformatf("%s ready c%0d", who, c), int'(r), int'(e.r));
        check($sformatf("%s remaining c%0d", who, c), int'(rm), e.rem);
    endtask

    task automatic handshake(input int n);
        @(negedge clk);
        check("d1 ready before start", int'(ready1), 1);
        check("d2 ready before start", int'(ready2), 1);
        start_valid = 1'b1;
        count       = W'(n);
        @(posedge clk);
        #1;
        start_valid = 1'b0;
        count       = W'($urandom);
    endtask

    // Runs cycles 0.. after acceptance; cut >= 0 pulses abort (or res) during that cycle.
    task automatic run_burst(input int n, input int cut, input bit is_rst, input bit junk,
                             input int s1, input int s2);
        int e1c, e2c, last;
        exp_t x1, x2;
        e1c  = end_cycle(n, H1, G1, cut, is_rst);
        e2c  = end_cycle(n, H2, G2, cut, is_rst);
        last = (e1c > e2c) ? e1c : e2c;
        for (int c = 0; c <= last; c++) begin
            @(negedge clk);
            x1 = model(n, H1, G1, c, cut, is_rst);
            x2 = model(n, H2, G2, c, cut, is_rst);
            cmp("d1", c, x1, pulse1, busy1, done1, ready1, rem1);
            cmp("d2", c, x2, pulse2, busy2, done2, ready2, rem2);
            if (c == cut) begin
                if (is_rst) res = 1'b1;
                else        abort = 1'b1;
            end
            // Requests while both units are mid-burst must be dropped, not queued.
            if (junk && x1.b && x2.b) begin
                start_valid = 1'($urandom_range(0, 1));
                count       = W'($urandom);
            end
            @(posedge clk);
            #1;
            res         = 1'b0;
            abort       = 1'b0;
            start_valid = 1'b0;
        end
        check("d1 pulse counter", pc1 - s1, pulses_exp(n, H1, G1, cut, is_rst));
        check("d2 pulse counter", pc2 - s2, pulses_exp(n, H2, G2, cut, is_rst));
    endtask

    task automatic burst(input int n, input int cut, input bit is_rst, input bit junk);
        int s1, s2;
        s1 = pc1;
        s2 = pc2;
        handshake(n);
        run_burst(n, cut, is_rst, junk, s1, s2);
    endtask

    // start_valid held through the DONE cycle of a zero-count burst: accepted one cycle later.
    task automatic done_contention();
        int s1, s2;
        s1 = pc1;
        s2 = pc2;
        @(negedge clk);
        start_valid = 1'b1;
        count       = 3'd0;
        @(posedge clk);
        #1;
        count = 3'd4;
        @(negedge clk);
        check("d1 done in DONE", int'(done1), 1);
        check("d1 ready in DONE", int'(ready1), 0);
        check("d2 done in DONE", int'(done2), 1);
        check("d2 ready in DONE", int'(ready2), 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("d1 no accept in DONE", int'(pulse1), 0);
        check("d1 idle after DONE", int'(busy1), 0);
        check("d1 ready after DONE", int'(ready1), 1);
        check("d2 no accept in DONE", int'(pulse2), 0);
        check("d2 ready after DONE", int'(ready2), 1);
        @(posedge clk);
        #1;
        start_valid = 1'b0;
        run_burst(4, -1, 1'b0, 1'b0, s1, s2);
    endtask

    // start_valid together with abort in IDLE must not be accepted.
    task automatic idle_abort();
        @(negedge clk);
        abort       = 1'b1;
        start_valid = 1'b1;
        count       = 3'd5;
        #1;
        check("d1 ready under abort", int'(ready1), 0);
        check("d2 ready under abort", int'(ready2), 0);
        @(posedge clk);
        #1;
        abort       = 1'b0;
        start_valid = 1'b0;
        @(negedge clk);
        check("d1 pulse after idle abort", int'(pulse1), 0);
        check("d1 busy after idle abort", int'(busy1), 0);
        check("d1 done after idle abort", int'(done1), 0);
        check("d2 pulse after idle abort", int'(pulse2), 0);
        check("d2 busy after idle abort", int'(busy2), 0);
        check("d1 ready after idle abort", int'(ready1), 1);
    endtask

    initial begin
        res         = 1'b1;
        start_valid = 1'b0;
        count       = '0;
        abort       = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        res = 1'b0;
        @(negedge clk);
        check("d1 reset pulse", int'(pulse1), 0);
        check("d1 reset busy", int'(busy1), 0);
        check("d1 reset done", int'(done1), 0);
        check("d1 reset remaining", int'(rem1), 0);
        check("d1 reset ready", int'(ready1), 1);
        check("d2 reset busy", int'(busy2), 0);
        check("d2 reset remaining", int'(rem2), 0);

        burst(3, -1, 1'b0, 1'b0);
        burst(0, -1, 1'b0, 1'b0);
        burst(7, -1, 1'b0, 1'b1);
        burst(5, 2, 1'b0, 1'b0);
        done_contention();
        idle_abort();
        burst(6, 3, 1'b1, 1'b0);
        burst(1, -1, 1'b0, 1'b0);

        for (int i = 0; i < 30; i++) begin
            int n, kind, span, cut;
            n    = $urandom_range(0, 7);
            kind = $urandom_range(0, 5);
            span = (n == 0) ? 1 : n * H2 + (n - 1) * G2 + 1;
            cut  = (kind <= 1) ? $urandom_range(0, span) : -1;
            burst(n, cut, (kind == 1), 1'b1);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
